hazard_ctrl: RTL and testbench

- Parametrised hazard control unit for the in-order integer pipeline.
- Generates operand-forwarding selects for Execute from NUM_FWD downstream producer stages.
- Detects load-use hazards precisely (Decode vs Execute), stalls for a configurable load latency, and stalls for multi-cycle Execute operations via a start/done handshake.
- Flushes on branch misprediction and Decode-stage redirects; sits beside the pipeline registers and drives their stall and flush enables.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_fwd_select.sv | 26 ++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard control unit.
// Optional multi-cycle support is selected with the HAZARD_MC_EN macro.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        MCBUSY  = 2'd2
    } hz_state_t;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    // Forwarding select value for producer stage k (0 is reserved for the register file)
    function automatic int fwd_idx(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// Priority encoder choosing the nearest producer stage whose destination
// matches one Execute source register. Register x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int FWD_W   = 2
)(
    input  logic [REG_W-1:0]         rs,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_we,
    output logic [FWD_W-1:0]         sel
);

    // Scan from oldest to youngest so the lowest matching index wins
    always_comb begin
        sel = FWD_W'(FWD_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] && (fwd_rd[k*REG_W +: REG_W] == rs) && (rs != '0)) begin
                sel = FWD_W'(fwd_idx(k));
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control unit: operand forwarding selects, load-use stall,
// mispredict / redirect flushes and (with HAZARD_MC_EN) multi-cycle
// Execute stalls. Stall/flush outputs are combinational so a hazard is
// covered in the cycle it is detected; reset forces every output low.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int REG_W    = 5,
    parameter  int NUM_FWD  = 2,
    parameter  int LOAD_LAT = 1,
    localparam int FWD_W    = $clog2(NUM_FWD + 1)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_W-1:0]         rs1_D,
    input  logic [REG_W-1:0]         rs2_D,
    input  logic [REG_W-1:0]         rs1_E,
    input  logic [REG_W-1:0]         rs2_E,
    input  logic [REG_W-1:0]         rd_E,
    input  logic                     regwe_E,
    input  logic                     load_E,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic                     mc_start_E,
    input  logic                     mc_done,
    input  logic                     branch_E,
    input  logic                     mispredict_E,
    input  logic                     branch_D,
    input  logic                     jump_D,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic [FWD_W-1:0]         fwdA_E,
    output logic [FWD_W-1:0]         fwdB_E,
    output logic                     busy
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    hz_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;

    hz_state_t          w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_lu;
    logic               w_mispred;
    logic               w_redirect;
    logic               w_stall_fd;
    logic               w_stall_e;
    logic               w_flush_e;
    logic               w_flush_mp;
    logic [FWD_W-1:0]   w_fwd_a;
    logic [FWD_W-1:0]   w_fwd_b;

`ifndef HAZARD_MC_EN
    // Handshake inputs are kept on the interface but have no effect here
    logic w_unused_mc;
    assign w_unused_mc = mc_start_E | mc_done;
`endif

    fwd_select #(.REG_W(REG_W), .NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd_a (
        .rs     (rs1_E),
        .fwd_rd (fwd_rd),
        .fwd_we (fwd_we),
        .sel    (w_fwd_a)
    );

    fwd_select #(.REG_W(REG_W), .NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd_b (
        .rs     (rs2_E),
        .fwd_rd (fwd_rd),
        .fwd_we (fwd_we),
        .sel    (w_fwd_b)
    );

    assign w_lu       = load_E && regwe_E && (rd_E != '0) &&
                        ((rd_E == rs1_D) || (rd_E == rs2_D));
    assign w_mispred  = branch_E && mispredict_E;
    assign w_redirect = branch_D || jump_D;

    // Next-state and per-cycle stall/flush decisions, highest priority first
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_stall_fd  = 1'b0;
        w_stall_e   = 1'b0;
        w_flush_e   = 1'b0;
        w_flush_mp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mispred) begin
                    w_flush_mp = 1'b1;
                    w_flush_e  = 1'b1;
                end else if (w_lu) begin
                    w_stall_fd = 1'b1;
                    w_flush_e  = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_nxt_state = LDSTALL;
                        w_nxt_cnt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
`ifdef HAZARD_MC_EN
                else if (mc_start_E && !mc_done) begin
                    w_stall_fd  = 1'b1;
                    w_stall_e   = 1'b1;
                    w_nxt_state = MCBUSY;
                end
`endif
            end
            LDSTALL: begin
                if (w_mispred) begin
                    w_flush_mp  = 1'b1;
                    w_flush_e   = 1'b1;
                    w_nxt_state = IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_stall_fd = 1'b1;
                    w_flush_e  = 1'b1;
                    w_nxt_cnt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_nxt_state = IDLE;
                    end
                end
            end
`ifdef HAZARD_MC_EN
            MCBUSY: begin
                if (!mc_done) begin
                    w_stall_fd = 1'b1;
                    w_stall_e  = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
`endif
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // State and load-latency counter; reset aborts any stall in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // A stalled Decode keeps its redirect and performs it once released
    assign StallF = !reset && w_stall_fd;
    assign StallD = !reset && w_stall_fd;
    assign StallE = !reset && w_stall_e;
    assign FlushD = !reset && (w_flush_mp || (w_redirect && !w_stall_fd));
    assign FlushE = !reset && w_flush_e;
    assign fwdA_E = reset ? '0 : w_fwd_a;
    assign fwdB_E = reset ? '0 : w_fwd_b;
    assign busy   = !reset && (r_state != IDLE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_LAT=2 for the
// main sequence and one with LOAD_LAT=4 for reset-abort and stall length.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst2;
    logic        rst4;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic        regwe_E, load_E;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic        mc_start_E, mc_done;
    logic        branch_E, mispredict_E, branch_D, jump_D;

    logic        sf2, sd2, se2, fd2, fe2, busy2;
    logic [1:0]  fa2, fb2;
    logic        sf4, sd4, se4, fd4, fe4, busy4;
    logic [1:0]  fa4, fb4;

    wire [7:0] ctl2 = {3'b000, sf2, sd2, se2, fd2, fe2};
    wire [7:0] ctl4 = {3'b000, sf4, sd4, se4, fd4, fe4};

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_W(5), .NUM_FWD(2), .LOAD_LAT(2)) dut2 (
        .clk(clk), .reset(rst2),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .regwe_E(regwe_E), .load_E(load_E), .fwd_rd(fwd_rd), .fwd_we(fwd_we),
        .mc_start_E(mc_start_E), .mc_done(mc_done),
        .branch_E(branch_E), .mispredict_E(mispredict_E),
        .branch_D(branch_D), .jump_D(jump_D),
        .StallF(sf2), .StallD(sd2), .StallE(se2), .FlushD(fd2), .FlushE(fe2),
        .fwdA_E(fa2), .fwdB_E(fb2), .busy(busy2)
    );

    hazard_ctrl #(.REG_W(5), .NUM_FWD(2), .LOAD_LAT(4)) dut4 (
        .clk(clk), .reset(rst4),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .regwe_E(regwe_E), .load_E(load_E), .fwd_rd(fwd_rd), .fwd_we(fwd_we),
        .mc_start_E(mc_start_E), .mc_done(mc_done),
        .branch_E(branch_E), .mispredict_E(mispredict_E),
        .branch_D(branch_D), .jump_D(jump_D),
        .StallF(sf4), .StallD(sd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4),
        .fwdA_E(fa4), .fwdB_E(fb4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0;
        regwe_E = 0; load_E = 0; fwd_rd = '0; fwd_we = '0;
        mc_start_E = 0; mc_done = 0;
        branch_E = 0; mispredict_E = 0; branch_D = 0; jump_D = 0;
    endtask

    task automatic set_lu();
        load_E = 1; regwe_E = 1; rd_E = 5'd7; rs2_D = 5'd7;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    initial begin
        int n;
        idle();
        rst2 = 1; rst4 = 1;
        // Hazard, forwarding and redirect inputs active while reset is held
        set_lu(); rs1_E = 5'd5; fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; branch_D = 1;
        half();
        chk("rst_ctl",  ctl2, 8'h00);
        chk("rst_fwdA", {6'b0, fa2}, 8'h00);
        chk("rst_busy", {7'b0, busy2}, 8'h00);
        idle();
        cyc();
        rst2 = 0;
        half();
        chk("idle_ctl", ctl2, 8'h00);

        // Forwarding priority and x0
        cyc();
        fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; rs1_E = 5'd5; rs2_E = 5'd0;
        half();
        chk("fwdA_near", {6'b0, fa2}, 8'd1);
        chk("fwdB_x0",   {6'b0, fb2}, 8'd0);
        cyc();
        fwd_rd = {5'd0, 5'd5};
        half();
        chk("fwdB_x0_s1", {6'b0, fb2}, 8'd0);
        cyc();
        fwd_we = 2'b10; fwd_rd = {5'd9, 5'd5}; rs2_E = 5'd9;
        half();
        chk("fwdA_we_off", {6'b0, fa2}, 8'd0);
        chk("fwdB_far",    {6'b0, fb2}, 8'd2);

        // Load-use with LOAD_LAT=2
        cyc(); idle(); set_lu();
        half();
        chk("lu_c0",      ctl2, 8'h19);
        chk("lu_c0_busy", {7'b0, busy2}, 8'd0);
        cyc(); idle();
        half();
        chk("lu_c1",      ctl2, 8'h19);
        chk("lu_c1_busy", {7'b0, busy2}, 8'd1);
        cyc();
        half();
        chk("lu_end",      ctl2, 8'h00);
        chk("lu_end_busy", {7'b0, busy2}, 8'd0);

        // Load with rd_E = x0 never stalls
        cyc(); load_E = 1; regwe_E = 1; rd_E = 5'd0; rs2_D = 5'd0;
        half();
        chk("lu_x0", ctl2, 8'h00);
        cyc(); idle();
        half();
        chk("lu_x0_busy", {7'b0, busy2}, 8'd0);

        // Mispredict beats load-use
        cyc(); set_lu(); branch_E = 1; mispredict_E = 1;
        half();
        chk("mp_lu",      ctl2, 8'h03);
        chk("mp_lu_busy", {7'b0, busy2}, 8'd0);
        cyc(); idle();
        half();
        chk("mp_after",      ctl2, 8'h00);
        chk("mp_after_busy", {7'b0, busy2}, 8'd0);

        // Redirect held back while stalled, performed on release
        cyc(); set_lu(); jump_D = 1;
        half();
        chk("rd_st0", ctl2, 8'h19);
        cyc(); idle(); jump_D = 1;
        half();
        chk("rd_st1", ctl2, 8'h19);
        cyc();
        half();
        chk("rd_rel", ctl2, 8'h02);
        cyc(); idle();

        // Mispredict during LDSTALL aborts the stall
        set_lu();
        half();
        cyc(); idle(); branch_E = 1; mispredict_E = 1;
        half();
        chk("mp_ld",      ctl2, 8'h03);
        chk("mp_ld_busy", {7'b0, busy2}, 8'd1);
        cyc(); idle();
        half();
        chk("mp_ld_after",      ctl2, 8'h00);
        chk("mp_ld_after_busy", {7'b0, busy2}, 8'd0);

`ifdef HAZARD_MC_EN
        // Multi-cycle op: done arrives four cycles after start
        cyc(); mc_start_E = 1;
        half();
        chk("mc_c0", ctl2, 8'h1C);
        for (int i = 1; i <= 3; i++) begin
            cyc(); idle();
            if (i == 2) begin branch_E = 1; mispredict_E = 1; end
            half();
            chk("mc_busy_ctl", ctl2, 8'h1C);
            chk("mc_busy",     {7'b0, busy2}, 8'd1);
        end
        cyc(); idle(); mc_done = 1;
        half();
        chk("mc_done_ctl",  ctl2, 8'h00);
        chk("mc_done_busy", {7'b0, busy2}, 8'd1);
        cyc(); idle();
        half();
        chk("mc_idle", {7'b0, busy2}, 8'd0);
        cyc(); mc_start_E = 1; mc_done = 1;
        half();
        chk("mc_same", ctl2, 8'h00);
        cyc(); idle();
        half();
        chk("mc_same_busy", {7'b0, busy2}, 8'd0);
`else
        // Multi-cycle handshake has no effect in this build
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); mc_start_E = 1;
            half();
            chk("mc_off_ctl",  ctl2, 8'h00);
            chk("mc_off_busy", {7'b0, busy2}, 8'd0);
        end
`endif

        // Reset during LDSTALL on the LOAD_LAT=4 instance
        cyc(); idle();
        cyc(); rst4 = 0;
        half();
        chk("r4_idle", ctl4, 8'h00);
        cyc(); set_lu();
        half();
        chk("r4_lu", ctl4, 8'h19);
        cyc(); idle();
        half();
        chk("r4_ld",      ctl4, 8'h19);
        chk("r4_ld_busy", {7'b0, busy4}, 8'd1);
        cyc();
        #2 rst4 = 1;
        #1;
        chk("r4_async_ctl",  ctl4, 8'h00);
        chk("r4_async_busy", {7'b0, busy4}, 8'd0);
        cyc(); rst4 = 0;
        half();
        chk("r4_rel_ctl",  ctl4, 8'h00);
        chk("r4_rel_busy", {7'b0, busy4}, 8'd0);
        cyc();
        half();
        chk("r4_rel2_ctl", ctl4, 8'h00);

        // Full load-use stall length on the LOAD_LAT=4 instance
        cyc(); set_lu();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            half();
            if (ctl4 == 8'h19) n++;
            cyc(); idle();
        end
        chk("r4_len", 8'(n), 8'd4);
        half();
        chk("r4_len_busy", {7'b0, busy4}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
